// File: rtl/dmux_rr_dispatcher.sv
// Round-robin dispatcher feeding a 1-to-8 demultiplexer.
// Accepts a serial bit stream over valid/ready and routes successive bits to
// the channels enabled in a per-frame mask, lowest channel first, holding
// each routed bit with a strobe for HOLD_CYCLES cycles.
module dmux_rr_dispatcher #(
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       chan_mask,
    input  logic             flush,
    output logic             out_data,
    output logic             sel0,
    output logic             sel1,
    output logic             sel2,
    output logic             out_strobe,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Hold counter is wide enough for the largest legal HOLD_CYCLES (16).
    localparam logic [4:0] HOLD_INIT = 5'(HOLD_CYCLES - 1);

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [7:0]       mask_q, mask_nxt;
    logic [4:0]       hold_cnt, hold_nxt;
    logic             data_q, data_nxt;
    logic [2:0]       sel_q, sel_nxt;
    logic             strobe_q, strobe_nxt;
    logic             done_q, done_nxt;
    logic [CNT_W-1:0] count_q, count_nxt;

    // Channels strictly above the current pointer, and the next one to serve.
    logic [8:0]       below_ptr;
    logic [7:0]       higher;
    logic             has_higher;

    // Priority encoder: index of the lowest set bit (0 when none is set).
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign below_ptr  = (9'd2 << ptr) - 9'd1;
    assign higher     = mask_q & ~below_ptr[7:0];
    assign has_higher = |higher;

    assign in_ready    = (state == ACCEPT) && !flush;
    assign out_data    = data_q;
    assign sel0        = sel_q[0];
    assign sel1        = sel_q[1];
    assign sel2        = sel_q[2];
    assign out_strobe  = strobe_q;
    assign frame_done  = done_q;
    assign frame_count = count_q;

    // State and output registers; all next values come from the block below.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            mask_q   <= '0;
            hold_cnt <= '0;
            data_q   <= 1'b0;
            sel_q    <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            mask_q   <= mask_nxt;
            hold_cnt <= hold_nxt;
            data_q   <= data_nxt;
            sel_q    <= sel_nxt;
            strobe_q <= strobe_nxt;
            done_q   <= done_nxt;
            count_q  <= count_nxt;
        end
    end

    // Next-state logic: flush first, then the IDLE/ACCEPT/HOLD sequencing.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_nxt  = state;
        ptr_nxt    = ptr;
        mask_nxt   = mask_q;
        hold_nxt   = hold_cnt;
        data_nxt   = data_q;
        sel_nxt    = sel_q;
        strobe_nxt = strobe_q;
        done_nxt   = 1'b0;
        count_nxt  = count_q;

        if (flush) begin
            state_nxt  = IDLE;
            strobe_nxt = 1'b0;
            ptr_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|chan_mask) begin
                        mask_nxt  = chan_mask;
                        ptr_nxt   = lowest_set(chan_mask);
                        state_nxt = ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        data_nxt   = in_data;
                        sel_nxt    = ptr;
                        strobe_nxt = 1'b1;
                        hold_nxt   = HOLD_INIT;
                        state_nxt  = HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        strobe_nxt = 1'b0;
                        if (!has_higher) begin
                            // Last enabled channel served: close the frame.
                            done_nxt  = 1'b1;
                            count_nxt = count_q + CNT_W'(1);
                            if (|chan_mask) begin
                                mask_nxt  = chan_mask;
                                ptr_nxt   = lowest_set(chan_mask);
                                state_nxt = ACCEPT;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            ptr_nxt   = lowest_set(higher);
                            state_nxt = ACCEPT;
                        end
                    end else begin
                        hold_nxt = hold_cnt - 5'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmux_rr_dispatcher.sv
// Self-checking bench for dmux_rr_dispatcher. Three instances with different
// HOLD_CYCLES / CNT_W share the stimulus; one is selected for checking at a
// time against a transaction-level model of the dispatch rules.
module tb_dmux_rr_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_data = 1'b0;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] chan_mask = 8'h00;

    always #5 clk = ~clk;

    logic       rdy_a, od_a, s0_a, s1_a, s2_a, stb_a, fd_a;
    logic       rdy_b, od_b, s0_b, s1_b, s2_b, stb_b, fd_b;
    logic       rdy_c, od_c, s0_c, s1_c, s2_c, stb_c, fd_c;
    logic [7:0] fc_a, fc_b;
    logic [1:0] fc_c;

    dmux_rr_dispatcher #(.HOLD_CYCLES(1), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_a), .chan_mask(chan_mask), .flush(flush),
        .out_data(od_a), .sel0(s0_a), .sel1(s1_a), .sel2(s2_a),
        .out_strobe(stb_a), .frame_done(fd_a), .frame_count(fc_a));

    dmux_rr_dispatcher #(.HOLD_CYCLES(3), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_b), .chan_mask(chan_mask), .flush(flush),
        .out_data(od_b), .sel0(s0_b), .sel1(s1_b), .sel2(s2_b),
        .out_strobe(stb_b), .frame_done(fd_b), .frame_count(fc_b));

    dmux_rr_dispatcher #(.HOLD_CYCLES(2), .CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_c), .chan_mask(chan_mask), .flush(flush),
        .out_data(od_c), .sel0(s0_c), .sel1(s1_c), .sel2(s2_c),
        .out_strobe(stb_c), .frame_done(fd_c), .frame_count(fc_c));

    // Observed outputs of the instance under check.
    int         dsel = 0;
    logic       o_ready, o_data, o_strobe, o_fd;
    logic [2:0] o_sel;
    logic [7:0] o_fc;

    always_comb begin
        case (dsel)
            1: begin
                o_ready = rdy_b; o_data = od_b; o_strobe = stb_b; o_fd = fd_b;
                o_sel = {s2_b, s1_b, s0_b}; o_fc = fc_b;
            end
            2: begin
                o_ready = rdy_c; o_data = od_c; o_strobe = stb_c; o_fd = fd_c;
                o_sel = {s2_c, s1_c, s0_c}; o_fc = {6'b0, fc_c};
            end
            default: begin
                o_ready = rdy_a; o_data = od_a; o_strobe = stb_a; o_fd = fd_a;
                o_sel = {s2_a, s1_a, s0_a}; o_fc = fc_a;
            end
        endcase
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model: channel schedule, remaining strobe cycles, counters.
    int         hold_len = 1;
    int         fc_mod = 256;
    bit         m_idle;
    int         m_h;
    logic [7:0] m_mask;
    int         m_ch;
    logic       m_data;
    logic [2:0] m_sel;
    logic       m_fd;
    int         m_fc;

    int   nacc, fd_seen, strobe_cycles;
    int   acc_sel_q[$];
    logic acc_data_q[$];
    int   fc_at_fd[$];

    function automatic int lowest(input logic [7:0] m);
        int r = -1;
        for (int i = 7; i >= 0; i--) if (m[i]) r = i;
        return r;
    endfunction

    function automatic int next_above(input logic [7:0] m, input int p);
        int r = -1;
        for (int i = 7; i > p; i--) if (m[i]) r = i;
        return r;
    endfunction

    task automatic select_dut(input int d);
        dsel     = d;
        hold_len = (d == 0) ? 1 : (d == 1) ? 3 : 2;
        fc_mod   = (d == 2) ? 4 : 256;
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_h = 0; m_mask = 8'h00; m_ch = 0;
        m_data = 1'b0; m_sel = 3'd0; m_fd = 1'b0; m_fc = 0;
    endtask

    task automatic do_reset(input logic [7:0] mask);
        in_valid = 1'b0; flush = 1'b0; chan_mask = mask; rst_n = 1'b0;
        model_reset();
        nacc = 0; fd_seen = 0; strobe_cycles = 0;
        acc_sel_q.delete(); acc_data_q.delete(); fc_at_fd.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs at the falling edge, compare every output with
    // the model, advance the model across the rising edge.
    task automatic cycle(input logic v, input logic d, input logic fl);
        logic e_ready, e_strobe, xfer;
        int   nxt;
        in_valid = v; in_data = d; flush = fl;
        #1;
        e_ready  = !m_idle && (m_h == 0) && !fl;
        e_strobe = (m_h > 0);
        vectors++;
        if (o_ready !== e_ready) begin
            miscompares++;
            $display("FAIL in_ready t=%0t got %b expected %b", $time, o_ready, e_ready);
        end
        vectors++;
        if (o_strobe !== e_strobe) begin
            miscompares++;
            $display("FAIL out_strobe t=%0t got %b expected %b", $time, o_strobe, e_strobe);
        end
        vectors++;
        if (o_data !== m_data) begin
            miscompares++;
            $display("FAIL out_data t=%0t got %b expected %b", $time, o_data, m_data);
        end
        vectors++;
        if (o_sel !== m_sel) begin
            miscompares++;
            $display("FAIL sel t=%0t got %0d expected %0d", $time, o_sel, m_sel);
        end
        vectors++;
        if (o_fd !== m_fd) begin
            miscompares++;
            $display("FAIL frame_done t=%0t got %b expected %b", $time, o_fd, m_fd);
        end
        vectors++;
        if (o_fc !== 8'(m_fc)) begin
            miscompares++;
            $display("FAIL frame_count t=%0t got %0d expected %0d", $time, o_fc, m_fc);
        end
        if (o_fd === 1'b1) begin
            fd_seen++;
            fc_at_fd.push_back(int'(o_fc));
        end
        if (o_strobe === 1'b1) strobe_cycles++;

        xfer = 1'b0;
        m_fd = 1'b0;
        if (fl) begin
            m_idle = 1'b1; m_h = 0; m_ch = 0;
        end else if (m_idle) begin
            if (chan_mask != 8'h00) begin
                m_mask = chan_mask; m_ch = lowest(chan_mask); m_idle = 1'b0;
            end
        end else if (m_h == 0) begin
            if (v) begin
                m_data = d; m_sel = 3'(m_ch); m_h = hold_len; nacc++; xfer = 1'b1;
            end
        end else begin
            m_h--;
            if (m_h == 0) begin
                nxt = next_above(m_mask, m_ch);
                if (nxt < 0) begin
                    m_fd = 1'b1;
                    m_fc = (m_fc + 1) % fc_mod;
                    if (chan_mask != 8'h00) begin
                        m_mask = chan_mask; m_ch = lowest(chan_mask);
                    end else begin
                        m_idle = 1'b1;
                    end
                end else begin
                    m_ch = nxt;
                end
            end
        end
        @(negedge clk);
        if (xfer) begin
            acc_sel_q.push_back(int'(o_sel));
            acc_data_q.push_back(o_data);
        end
    endtask

    task automatic test_reset();
        select_dut(0);
        rst_n = 1'b0; chan_mask = 8'hFF; in_valid = 1'b1; in_data = 1'b1;
        #3;
        vectors++;
        if ({o_ready, o_data, o_sel, o_strobe, o_fd} !== 7'b0 || o_fc !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_values got rdy=%b d=%b sel=%0d stb=%b fd=%b fc=%0d expected all 0",
                     o_ready, o_data, o_sel, o_strobe, o_fd, o_fc);
        end
    endtask

    task automatic test_full_mask();
        logic [7:0] pat = 8'h4D;  // bits 1,0,1,1,0,0,1,0 in arrival order
        select_dut(0);
        do_reset(8'hFF);
        for (int i = 0; i < 24; i++) cycle(nacc < 9, pat[nacc % 8], 1'b0);
        vectors++;
        if (acc_sel_q.size() != 9) begin
            miscompares++;
            $display("FAIL full_mask_count got %0d expected 9", acc_sel_q.size());
        end
        for (int i = 0; i < acc_sel_q.size(); i++) begin
            vectors++;
            if (acc_sel_q[i] != i % 8 || acc_data_q[i] !== pat[i % 8]) begin
                miscompares++;
                $display("FAIL full_mask_bit%0d got sel=%0d d=%b expected sel=%0d d=%b",
                         i, acc_sel_q[i], acc_data_q[i], i % 8, pat[i % 8]);
            end
        end
        vectors++;
        if (fd_seen != 1 || o_fc !== 8'd1) begin
            miscompares++;
            $display("FAIL full_mask_frame got done=%0d fc=%0d expected 1 and 1", fd_seen, o_fc);
        end
    endtask

    task automatic test_sparse_mask();
        int exp_s[4] = '{0, 3, 5, 0};
        select_dut(1);
        do_reset(8'h29);
        for (int i = 0; i < 24; i++) cycle(nacc < 4, 1'($urandom % 2), 1'b0);
        vectors++;
        if (acc_sel_q.size() != 4 || strobe_cycles != 12 || fd_seen != 1) begin
            miscompares++;
            $display("FAIL sparse_mask got n=%0d strobe_cyc=%0d done=%0d expected 4 12 1",
                     acc_sel_q.size(), strobe_cycles, fd_seen);
        end
        for (int i = 0; i < acc_sel_q.size() && i < 4; i++) begin
            vectors++;
            if (acc_sel_q[i] != exp_s[i]) begin
                miscompares++;
                $display("FAIL sparse_sel%0d got %0d expected %0d", i, acc_sel_q[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_mask_change();
        select_dut(0);
        do_reset(8'h0F);
        for (int i = 0; i < 24; i++) begin
            if (nacc >= 1) chan_mask = 8'hF0;
            cycle(nacc < 7, 1'($urandom % 2), 1'b0);
        end
        vectors++;
        if (acc_sel_q.size() != 7) begin
            miscompares++;
            $display("FAIL mask_change_count got %0d expected 7", acc_sel_q.size());
        end
        for (int i = 0; i < acc_sel_q.size(); i++) begin
            vectors++;
            if (acc_sel_q[i] != i) begin
                miscompares++;
                $display("FAIL mask_change_sel%0d got %0d expected %0d", i, acc_sel_q[i], i);
            end
        end
    endtask

    task automatic test_zero_mask();
        select_dut(0);
        do_reset(8'h00);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0);
        vectors++;
        if (o_ready !== 1'b0 || o_strobe !== 1'b0 || o_sel !== 3'd0) begin
            miscompares++;
            $display("FAIL zero_mask_idle got rdy=%b stb=%b sel=%0d expected 0 0 0",
                     o_ready, o_strobe, o_sel);
        end
        chan_mask = 8'h80;
        for (int i = 0; i < 12; i++) cycle(nacc < 3, 1'b1, 1'b0);
        vectors++;
        if (acc_sel_q.size() != 3 || fd_seen != 3 || o_fc !== 8'd3) begin
            miscompares++;
            $display("FAIL single_channel got n=%0d done=%0d fc=%0d expected 3 3 3",
                     acc_sel_q.size(), fd_seen, o_fc);
        end
        for (int i = 0; i < acc_sel_q.size(); i++) begin
            vectors++;
            if (acc_sel_q[i] != 7) begin
                miscompares++;
                $display("FAIL single_channel_sel%0d got %0d expected 7", i, acc_sel_q[i]);
            end
        end
    endtask

    task automatic test_flush();
        select_dut(1);
        do_reset(8'hFF);
        for (int i = 0; i < 30 && nacc < 4; i++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);   // flush while holding channel 3
        cycle(1'b0, 1'b0, 1'b0);   // IDLE -> ACCEPT
        cycle(1'b1, 1'b0, 1'b1);   // flush with valid high: no transfer
        cycle(1'b0, 1'b0, 1'b0);
        vectors++;
        if (acc_sel_q.size() != 4 || o_sel !== 3'd3 || o_strobe !== 1'b0 || fd_seen != 0
            || o_data !== 1'b1) begin
            miscompares++;
            $display("FAIL flush got n=%0d sel=%0d stb=%b done=%0d d=%b expected 4 3 0 0 1",
                     acc_sel_q.size(), o_sel, o_strobe, fd_seen, o_data);
        end
    endtask

    task automatic test_async_reset();
        select_dut(1);
        do_reset(8'h02);
        for (int i = 0; i < 40 && nacc < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        vectors++;
        if (o_strobe !== 1'b1 || o_fc !== 8'd2 || o_sel !== 3'd1) begin
            miscompares++;
            $display("FAIL pre_reset got stb=%b fc=%0d sel=%0d expected 1 2 1",
                     o_strobe, o_fc, o_sel);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_ready, o_data, o_sel, o_strobe, o_fd} !== 7'b0 || o_fc !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset got rdy=%b d=%b sel=%0d stb=%b fd=%b fc=%0d expected all 0",
                     o_ready, o_data, o_sel, o_strobe, o_fd, o_fc);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_count_wrap();
        int exp_fc[5] = '{1, 2, 3, 0, 1};
        select_dut(2);
        do_reset(8'h01);
        for (int i = 0; i < 40 && fd_seen < 5; i++) cycle(nacc < 5, 1'b0, 1'b0);
        vectors++;
        if (fc_at_fd.size() != 5) begin
            miscompares++;
            $display("FAIL wrap_frames got %0d expected 5", fc_at_fd.size());
        end
        for (int i = 0; i < fc_at_fd.size() && i < 5; i++) begin
            vectors++;
            if (fc_at_fd[i] != exp_fc[i]) begin
                miscompares++;
                $display("FAIL wrap_count%0d got %0d expected %0d", i, fc_at_fd[i], exp_fc[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int d = 0; d < 3; d++) begin
            select_dut(d);
            do_reset(8'($urandom_range(255, 1)));
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(99) < 5)
                    chan_mask = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
                cycle(1'($urandom_range(99) < 70), 1'($urandom % 2),
                      1'($urandom_range(99) < 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_mask_change();
        test_zero_mask();
        test_flush();
        test_async_reset();
        test_count_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule

// File: doc/dmux_rr_dispatcher.md
Name: dmux_rr_dispatcher

Overview:
Round-robin dispatcher that sits directly upstream of the 1-to-8 demultiplexer and drives its data input and three select lines. It accepts a serial bit stream over a valid/ready handshake and routes successive bits to the enabled channels in ascending order, wrapping 7->0. The per-frame channel set comes from an 8-bit mask. Each routed bit is held stable with a strobe for a configurable number of cycles so downstream per-channel capture registers can sample it.

Parameters:
HOLD_CYCLES, 1, cycles out_strobe stays high per dispatched bit; legal range 1..16.
CNT_W, 8, width of the frame counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  1  serial data bit
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  dispatcher can accept a bit this cycle
chan_mask  input  8  enabled channels; bit i enables channel i
flush  input  1  synchronous abort to IDLE
out_data  output  1  drives the demux data input
sel0  output  1  channel index bit 0 to the demux
sel1  output  1  channel index bit 1
sel2  output  1  channel index bit 2
out_strobe  output  1  high while out_data/sel are presented for capture
frame_done  output  1  one-cycle pulse after the last enabled channel of a frame is served
frame_count  output  CNT_W  frames completed, wraps modulo 2^CNT_W

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: out_data=0, sel2..0=000, out_strobe=0, frame_done=0, frame_count=0. Internal state is IDLE, ptr=0, mask_q=0, hold_cnt=0.
- in_ready = (state==ACCEPT) && !flush. It is combinational from state and is 0 during reset.
- Handshake: a transfer occurs on an edge where in_valid && in_ready. in_valid may rise at any time. Dropping in_valid without a transfer is legal.
- IDLE: in_ready=0.
  - If chan_mask!=0: latch mask_q<=chan_mask, set ptr to the lowest set bit, go to ACCEPT.
  - Otherwise remain in IDLE.
- ACCEPT, on transfer:
  - out_data<=in_data; {sel2,sel1,sel0}<=ptr; out_strobe<=1; hold_cnt<=HOLD_CYCLES-1; go to HOLD.
  - Latency: the bit appears on out_data/sel one cycle after the accepting edge.
- HOLD: in_ready=0. out_strobe stays high for exactly HOLD_CYCLES cycles.
  - When hold_cnt==0 at an edge, clear out_strobe.
  - If ptr has no higher set bit in mask_q, the frame ends:
    - Pulse frame_done for one cycle and increment frame_count, wrapping all-ones->0.
    - If chan_mask!=0, re-latch mask_q<=chan_mask, set ptr to its lowest set bit, and go to ACCEPT.
    - Otherwise go to IDLE.
  - If the frame has not ended, set ptr to the next higher set bit of mask_q and go to ACCEPT.
  - frame_done is therefore coincident with in_ready returning high, and an accept in that same cycle is legal.
- out_data and sel hold their last values after the strobe drops until the next transfer. They change only on an accepting edge.
- chan_mask is sampled only at frame start (leaving IDLE or at frame end). Mid-frame changes are ignored until the next frame.
- chan_mask==0 at a frame boundary: go to IDLE, in_ready=0, with no extra frame_done.
- Single-bit mask: every bit goes to the same channel, and every bit ends a frame.
- flush (synchronous) has priority over everything except reset. At the next edge:
  - state<=IDLE, out_strobe<=0, frame_done<=0, ptr<=0.
  - out_data, sel and frame_count retain their values.
  - No transfer occurs in a cycle with flush=1.
- Reset mid-HOLD: all outputs immediately take their reset values (asynchronous).
- Pointer search: priority encode of mask_q & ~((2<<ptr)-1) for the next channel, and of mask_q for the lowest channel. Both are combinational and finish in a single cycle.

Test Plan:
- Mask 0xFF, HOLD_CYCLES=1, in_valid held high, bits 1,0,1,1,0,0,1,0 -> sel steps 0..7 on alternate cycles, out_data tracks each bit, frame_done pulses once with sel=7 held, frame_count=1, then sel returns to 0.
- Mask 0x29 (channels 0,3,5), HOLD_CYCLES=3 -> out_strobe high 3 cycles per bit, sel sequence 0,3,5,0; in_ready low during HOLD; frame_done coincides with in_ready rising after channel 5.
- Mask changed 0x0F->0xF0 after the first bit of a frame -> the remaining bits go to channels 1,2,3, then the next frame uses 4,5,6,7.
- Mask 0x00 at reset release -> in_ready stays 0 and outputs stay at reset values; set mask 0x80 -> accept, sel=7, frame_done after every bit, frame_count increments each bit.
- flush asserted during HOLD at sel=3 -> next cycle out_strobe=0, state IDLE, sel=3 held, no frame_done; a flush cycle with in_valid=1 is not accepted.
- rst_n pulsed low mid-HOLD -> out_strobe, sel, out_data and frame_count are 0 immediately; CNT_W=2 run of 5 frames -> frame_count wraps 3->0->1.
